arb_req_queue: RTL
==================

// Module: arb_req_queue
// PURPOSE
//  Two-port request front end for the two-way round-robin grant arbiter.
//  Buffers incoming transactions per port in small FIFOs and drives req_1/req_2.
//  Consumes grant_1/grant_2 and moves the granted head entry into one shared
//  output register. That register carries a valid/ready handshake and a source tag.
// PARAMETERS
//  DATA_W  8  width of each transaction payload
//  DEPTH   4  entries per port FIFO; power of two, >= 2
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             synchronous, active-high reset
//  in1_valid  in   1             port 1 producer has data
//  in1_ready  out  1             port 1 FIFO can accept (= !full_1)
//  in1_data   in   DATA_W        port 1 payload
//  in2_valid  in   1             port 2 producer has data
//  in2_ready  out  1             port 2 FIFO can accept (= !full_2)
//  in2_data   in   DATA_W        port 2 payload
//  req_1      out  1             to arbiter: port 1 FIFO non-empty
//  req_2      out  1             to arbiter: port 2 FIFO non-empty
//  grant_1    in   1             from arbiter, registered, 1 cycle after req
//  grant_2    in   1             from arbiter
//  out_valid  out  1             output register holds a transaction
//  out_ready  in   1             downstream accepts
//  out_data   out  DATA_W        transaction payload
//  out_src    out  1             0 = came from port 1, 1 = came from port 2
//  cnt_1      out  $clog2(DEPTH+1)  port 1 occupancy
//  cnt_2      out  $clog2(DEPTH+1)  port 2 occupancy
//  grant_err  out  1             sticky: grant_1 and grant_2 were high together
// BEHAVIOUR
//  Reset (sync): all pointers = 0; cnt_x = 0; out_valid = 0; out_data = 0.
//   Also out_src = 0 and grant_err = 0. Hence in_ready = 1 and req = 0 the
//   cycle after reset. FIFO contents are not reset.
//  FIFO x: circular buffer with wr/rd pointers of $clog2(DEPTH) bits.
//   Pointers wrap DEPTH-1 -> 0. cnt_x tracks occupancy 0..DEPTH.
//  Push x: in_x_valid && in_x_ready at the edge. in_x_ready = (cnt_x != DEPTH).
//   It is combinational from registered state only. A full FIFO refuses a push
//   even when a pop happens in the same cycle.
//  req_x = (cnt_x != 0), combinational from registers.
//  slot_free = !out_valid || out_ready.
//  Pop x: grant_x && cnt_x != 0 && slot_free.
//   Head goes into out_data; out_src = x-1; out_valid <= 1.
//  Grant with an empty FIFO is ignored. This is normal: the arbiter's
//   registered grant lags req by 1 cycle, so a stale grant can follow the
//   last pop.
//  Grant while the slot is not free is dropped. The entry stays, req stays
//   high, and the arbiter re-grants later. Payload is never lost or duplicated.
//  Both grants high: serve port 1 only and set grant_err (cleared only by reset).
//  out_valid && out_ready with no pop: out_valid <= 0 next cycle.
//   With a pop: the new entry replaces the old one (back-to-back, 1 item/cycle).
//  Push and pop on the same FIFO in one cycle: cnt_x unchanged, both pointers advance.
//  Latency: in_x push at edge k -> req_x high in cycle k+1.
//   The arbiter then grants in cycle k+2 -> out_valid in cycle k+3.
//  Reset mid-operation: FIFOs and the output register empty immediately.
//   Stale grants after reset are ignored because the FIFOs are empty.
// TESTING
//  Reset then idle -> req_1 = req_2 = 0, out_valid = 0, in1_ready = in2_ready = 1, cnt = 0.
//  Push 0xA1 on port 1, out_ready = 1, arbiter attached -> out_data = 0xA1 and out_src = 0.
//   This appears exactly 3 cycles after the push. Then exactly one output, no duplicate.
//  Fill both FIFOs with 4 items each (0x10.., 0x20..), out_ready = 1 -> outputs alternate
//   ports 2,1,2,1,... with per-port order preserved. in_ready is low while cnt = 4.
//  out_ready = 0 for 5 cycles with both FIFOs loaded -> only one item in the output register.
//   cnt values are unchanged apart from that single pop. Release -> all 8 items delivered.
//  Force grant_1 = grant_2 = 1 with both non-empty -> port 1 popped, grant_err = 1 until reset.
//  Assert reset with 3 entries queued and out_valid = 1 -> next cycle out_valid = 0,
//   cnt = 0, req = 0. A pending grant produces no output.

Source files
------------

// File: rtl/arb_req_queue.sv
// Per-port request FIFOs plus one shared output register for a two-way round-robin arbiter.
// Latency: push -> req next cycle; accepted grant -> out_valid next cycle.
// Backpressure: a full FIFO drops in_ready; a grant arriving while the output slot is busy is dropped.
module arb_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in1_valid,
  output logic                       in1_ready,
  input  logic [DATA_W-1:0]          in1_data,
  input  logic                       in2_valid,
  output logic                       in2_ready,
  input  logic [DATA_W-1:0]          in2_data,
  output logic                       req_1,
  output logic                       req_2,
  input  logic                       grant_1,
  input  logic                       grant_2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_src,
  output logic [$clog2(DEPTH+1)-1:0] cnt_1,
  output logic [$clog2(DEPTH+1)-1:0] cnt_2,
  output logic                       grant_err
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic              push_1, push_2, pop_1, pop_2, slot_free;
  logic [DATA_W-1:0] head_1, head_2;

  assign in1_ready = (cnt_1 != CNT_FULL);
  assign in2_ready = (cnt_2 != CNT_FULL);
  assign push_1    = in1_valid && in1_ready;
  assign push_2    = in2_valid && in2_ready;
  assign req_1     = (cnt_1 != '0);
  assign req_2     = (cnt_2 != '0);
  assign slot_free = !out_valid || out_ready;

  // Grants on an empty FIFO are stale and ignored; port 1 wins a double grant.
  assign pop_1 = grant_1 && req_1 && slot_free;
  assign pop_2 = grant_2 && !grant_1 && req_2 && slot_free;

  arb_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
    .clk    (clk),
    .reset  (reset),
    .push   (push_1),
    .pop    (pop_1),
    .wr_dat (in1_data),
    .rd_dat (head_1),
    .cnt    (cnt_1)
  );

  arb_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
    .clk    (clk),
    .reset  (reset),
    .push   (push_2),
    .pop    (pop_2),
    .wr_dat (in2_data),
    .rd_dat (head_2),
    .cnt    (cnt_2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      if (pop_1 || pop_2) begin
        out_valid <= 1'b1;
        out_data  <= pop_1 ? head_1 : head_2;
        out_src   <= pop_2;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (grant_1 && grant_2) begin
        grant_err <= 1'b1;
      end
    end
  end
endmodule

// Circular-buffer FIFO with occupancy count; head is always visible on rd_dat.
// Latency: a push is visible at the head (when empty) the cycle after the write edge.
// Backpressure: caller must not push when cnt == DEPTH nor pop when cnt == 0.
module arb_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wr_dat,
  output logic [DATA_W-1:0]          rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  assign rd_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end
endmodule
